mdu_sequencer: RTL and testbench
================================

Name: mdu_sequencer

Overview:
- Multi-cycle RV32M multiply/divide sequencer alongside the single-cycle ALU in the execute stage.
- Accepts one M-extension operation per handshake and iterates one bit per cycle using its own internal adder/subtractor.
- Returns a single-cycle result pulse. Drives busy so the pipeline controller stalls fetch/decode while it runs.
- Only one operation is in flight at a time; there is no queueing.

Parameters:
- WIDTH, 32, operand/result width; iteration count equals WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start_valid  input  1  execute stage presents an M operation.
- start_ready  output  1  sequencer can accept; equals (state==IDLE).
- mdu_op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- operand1  input  WIDTH  rs1 value (multiplicand/dividend).
- operand2  input  WIDTH  rs2 value (multiplier/divisor).
- flush  input  1  pipeline kill; aborts any operation.
- result_valid  output  1  one-cycle pulse, result valid.
- result  output  WIDTH  final value; holds until next result_valid.
- busy  output  1  high in CALC and DONE states.

Behaviour:
- Reset (async on rst_n low, released synchronously to clk):
  - state=IDLE; result=0; result_valid=0; busy=0; start_ready=1.
  - All internal registers (accumulator, quotient, counter, sign flags) cleared.
- States: IDLE, CALC, DONE.
- Accept condition: start_valid && start_ready && !flush in IDLE. On accept, latch mdu_op and operands; inputs are don't-care afterwards.
- IDLE -> CALC on accept, unless a special case below applies, which goes IDLE -> DONE.
- CALC runs exactly WIDTH cycles on a 6-bit down-counter loaded with WIDTH; CALC -> DONE when counter reaches 0.
- DONE lasts one cycle: result_valid=1 and result updated in the same cycle; DONE -> IDLE.
- Latency: accept at edge T gives result_valid high in cycle T+WIDTH+1 (33 for WIDTH=32); special cases give result_valid in cycle T+1.
- Back-to-back: a new start may be accepted on the cycle after DONE (IDLE); no bubble beyond that.
- Multiply:
  - Operands converted to magnitudes per signedness: MUL/MULH both signed; MULHSU op1 signed, op2 unsigned; MULHU both unsigned.
  - Shift-add into a 2*WIDTH product; negated at DONE if sign flags differ.
  - MUL returns low WIDTH bits; the others return high WIDTH bits.
- Divide:
  - Restoring, unsigned on magnitudes: DIV/REM signed, DIVU/REMU unsigned.
  - Quotient sign = sign(op1) XOR sign(op2); remainder sign = sign(op1).
- Special cases (no CALC):
  - Divisor 0: DIV/DIVU -> all ones (0xFFFFFFFF); REM/REMU -> operand1.
  - Signed overflow (op1 = 0x80000000, op2 = 0xFFFFFFFF): DIV -> 0x80000000; REM -> 0.
- Flush:
  - In CALC or DONE: next state IDLE, result_valid forced 0 that cycle, result register unchanged.
  - Flush in IDLE blocks acceptance.
  - Flush has priority over all transitions.
- Reset mid-operation: immediate return to reset values; no result_valid.
- start_valid while busy is ignored (start_ready=0); the requester must hold it.
- All arithmetic is modulo 2^WIDTH on outputs; no exceptions are raised.

Test Plan:
- Reset asserted during CALC, cycle 10 -> outputs immediately at reset values; after release start_ready=1, no result_valid pulse.
- MUL 7 x 0xFFFFFFFA (-6), accept at cycle 0 -> result_valid only in cycle 33, result=0xFFFFFFD6; busy high cycles 1–33.
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF in cycle 1. REM 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000 in cycle 1. REM with those operands -> 0.
- Flush at CALC cycle 15 -> no result_valid, result retains prior value, start_ready=1 next cycle. Then back-to-back MUL 3x4 and DIVU 12/4 -> results 12 and 3, pulses 34 cycles apart.

Source files
------------

// File: rtl/mdu_sequencer.sv
// Multi-cycle RV32M multiply/divide sequencer: one bit per cycle using a shared
// adder/subtractor, one operation in flight, single-cycle result pulse.
module mdu_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [2:0]       mdu_op,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  input  logic             flush,
  output logic             result_valid,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] acc_hi, acc_lo, mcand;
  logic [5:0]       cnt;
  logic             neg_q, neg_r;
  logic [WIDTH-1:0] pend, result_q;

  logic             s1, s2, sign1, sign2, div_zero, ovf;
  logic [WIDTH-1:0] mag1, mag2, special;
  logic [WIDTH:0]   add_a, add_b, sum;
  logic [WIDTH-1:0] hi_nx, lo_nx, quot, remv, final_val;
  logic [2*WIDTH-1:0] prod, prod_s;

  always_comb begin
    if (mdu_op[2]) begin
      s1 = ~mdu_op[0];
      s2 = ~mdu_op[0];
    end else begin
      s1 = ~(mdu_op[1] & mdu_op[0]);
      s2 = ~mdu_op[1];
    end
    sign1    = s1 & operand1[WIDTH-1];
    sign2    = s2 & operand2[WIDTH-1];
    mag1     = sign1 ? -operand1 : operand1;
    mag2     = sign2 ? -operand2 : operand2;
    div_zero = mdu_op[2] && (operand2 == '0);
    ovf      = mdu_op[2] && !mdu_op[0] && (operand1 == MINV) && (operand2 == '1);
    if (div_zero)
      special = mdu_op[1] ? operand1 : '1;
    else
      special = mdu_op[1] ? '0 : MINV;
  end

  // Divide shifts the partial remainder in and subtracts; multiply adds the
  // multiplicand to the upper half when the current multiplier bit is set.
  always_comb begin
    add_a = op_q[2] ? {acc_hi, acc_lo[WIDTH-1]} : {1'b0, acc_hi};
    add_b = op_q[2] ? ~{1'b0, mcand} : {1'b0, mcand};
    sum   = add_a + add_b + {{WIDTH{1'b0}}, op_q[2]};
    if (op_q[2]) begin
      hi_nx = sum[WIDTH] ? add_a[WIDTH-1:0] : sum[WIDTH-1:0];
      lo_nx = {acc_lo[WIDTH-2:0], ~sum[WIDTH]};
    end else if (acc_lo[0]) begin
      {hi_nx, lo_nx} = {sum, acc_lo[WIDTH-1:1]};
    end else begin
      {hi_nx, lo_nx} = {1'b0, acc_hi, acc_lo[WIDTH-1:1]};
    end
    prod   = {hi_nx, lo_nx};
    prod_s = neg_q ? -prod : prod;
    quot   = neg_q ? -lo_nx : lo_nx;
    remv   = neg_r ? -hi_nx : hi_nx;
    if (op_q[2])
      final_val = op_q[1] ? remv : quot;
    else
      final_val = (op_q[1:0] == 2'b00) ? prod_s[WIDTH-1:0] : prod_s[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_q     <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      mcand    <= '0;
      cnt      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      pend     <= '0;
      result_q <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (start_valid) begin
          op_q  <= mdu_op;
          neg_q <= sign1 ^ sign2;
          neg_r <= sign1;
          if (div_zero || ovf) begin
            pend  <= special;
            state <= DONE;
          end else begin
            mcand  <= mdu_op[2] ? mag2 : mag1;
            acc_lo <= mdu_op[2] ? mag1 : mag2;
            acc_hi <= '0;
            cnt    <= 6'(WIDTH);
            state  <= CALC;
          end
        end
        CALC: begin
          acc_hi <= hi_nx;
          acc_lo <= lo_nx;
          cnt    <= cnt - 6'd1;
          if (cnt == 6'd1) begin
            pend  <= final_val;
            state <= DONE;
          end
        end
        DONE: begin
          result_q <= pend;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A flush during DONE must suppress the pulse and keep the old result
  // visible, so the new value is only committed when DONE completes.
  assign result_valid = (state == DONE) && !flush;
  assign result       = result_valid ? pend : result_q;
  assign start_ready  = (state == IDLE);
  assign busy         = (state != IDLE);

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: scoreboard of expected results and latencies.
module tb_mdu_sequencer;

  logic        clk, rst_n, start_valid, start_ready, flush, result_valid, busy;
  logic [2:0]  mdu_op;
  logic [31:0] operand1, operand2, result;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t exp_q[$];

  mdu_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
    .mdu_op(mdu_op), .operand1(operand1), .operand2(operand2), .flush(flush),
    .result_valid(result_valid), .result(result), .busy(busy)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub, p;
    logic signed [31:0] x, y;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    x = a;
    y = b;
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: if (b == 0) return 32'hFFFF_FFFF;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            else return x / y;
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: if (b == 0) return a;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            else return x % y;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && (b == 0)) return 1;
    if (op[2] && !op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Issues one operation and observes its result; cycle 1 is the cycle after the accept edge.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] got, output int lat, output bit busy_ok);
    @(negedge clk);
    mdu_op = op; operand1 = a; operand2 = b; start_valid = 1;
    @(posedge clk);
    #1 start_valid = 0; operand1 = $urandom; operand2 = $urandom; mdu_op = 3'($urandom);
    lat = -1; busy_ok = 1; got = '0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (!busy) busy_ok = 0;
      if (result_valid) begin
        lat = k; got = result;
        break;
      end
    end
  endtask

  task automatic run_vectors(input vec_t v[$], input string tag);
    logic [31:0] got;
    int lat;
    bit bok;
    vec_t e;
    foreach (v[i]) begin
      exp_q.push_back(v[i]);
      run_op(v[i].op, v[i].a, v[i].b, got, lat, bok);
      e = exp_q.pop_front();
      checks++;
      if (got !== e.exp) begin
        errors++;
        $display("FAIL %s[%0d] result op=%0d a=%h b=%h got=%h exp=%h", tag, i, e.op, e.a, e.b, got, e.exp);
      end
      checks++;
      if (lat != e.lat) begin
        errors++;
        $display("FAIL %s[%0d] latency got=%0d exp=%0d", tag, i, lat, e.lat);
      end
      checks++;
      if (!bok) begin
        errors++;
        $display("FAIL %s[%0d] busy low before result got=0 exp=1", tag, i);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1; start_valid = 0; flush = 0; mdu_op = 0; operand1 = 0; operand2 = 0;
    #2 rst_n = 0;
    #1;
    checks++;
    if ({start_ready, busy, result_valid} !== 3'b100 || result !== 32'h0) begin
      errors++;
      $display("FAIL reset_values got rdy/busy/vld=%b result=%h exp=100 result=0",
               {start_ready, busy, result_valid}, result);
    end
    repeat (3) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_mul();
    vec_t v[$];
    v.push_back('{3'd0, 32'd7, 32'hFFFF_FFFA, 32'hFFFF_FFD6, 33});
    v.push_back('{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33});
    v.push_back('{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33});
    v.push_back('{3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 33});
    run_vectors(v, "mul");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    mdu_op = 3'd0; operand1 = 32'd9; operand2 = 32'd9; start_valid = 1;
    @(posedge clk);
    #1 start_valid = 0;
    repeat (10) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_busy got=%b exp=1", busy);
    end
    rst_n = 0;
    #1;
    checks++;
    if ({start_ready, busy, result_valid} !== 3'b100 || result !== 32'h0) begin
      errors++;
      $display("FAIL rstmid_values got rdy/busy/vld=%b result=%h exp=100 result=0",
               {start_ready, busy, result_valid}, result);
    end
    @(negedge clk);
    rst_n = 1;
    begin
      bit pulse = 0;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (result_valid) pulse = 1;
      end
      checks++;
      if (pulse || start_ready !== 1'b1) begin
        errors++;
        $display("FAIL rstmid_after got pulse=%b rdy=%b exp pulse=0 rdy=1", pulse, start_ready);
      end
    end
  endtask

  task automatic test_div();
    vec_t v[$];
    v.push_back('{3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33});
    v.push_back('{3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33});
    v.push_back('{3'd5, 32'd100, 32'd7, 32'd14, 33});
    v.push_back('{3'd7, 32'd100, 32'd7, 32'd2, 33});
    run_vectors(v, "div");
  endtask

  task automatic test_flush();
    bit pulse;
    @(negedge clk);
    mdu_op = 3'd0; operand1 = 32'd3; operand2 = 32'd5; start_valid = 1;
    @(posedge clk);
    #1 start_valid = 0;
    repeat (15) @(negedge clk);
    flush = 1;
    checks++;
    if (result_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_vld got=%b exp=0", result_valid);
    end
    @(posedge clk);
    #1 flush = 0;
    @(negedge clk);
    checks++;
    if (start_ready !== 1'b1 || busy !== 1'b0 || result !== 32'd2) begin
      errors++;
      $display("FAIL flush_state got rdy=%b busy=%b result=%h exp rdy=1 busy=0 result=00000002",
               start_ready, busy, result);
    end
    // flush in IDLE must block acceptance
    flush = 1; start_valid = 1; mdu_op = 3'd0; operand1 = 32'd1; operand2 = 32'd1;
    @(posedge clk);
    #1 flush = 0; start_valid = 0;
    pulse = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (result_valid || busy) pulse = 1;
    end
    checks++;
    if (pulse) begin
      errors++;
      $display("FAIL flush_no_result got activity=1 exp=0");
    end
  endtask

  task automatic test_special();
    vec_t v[$];
    v.push_back('{3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1});
    v.push_back('{3'd6, 32'd5, 32'd0, 32'd5, 1});
    v.push_back('{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1});
    v.push_back('{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1});
    run_vectors(v, "special");
  endtask

  task automatic test_random();
    vec_t v[$];
    vec_t t;
    for (int i = 0; i < 10; i++) begin
      t.op = 3'($urandom);
      t.a  = $urandom;
      t.b  = (i == 3) ? 32'd0 : ((i % 2) ? $urandom : 32'($urandom_range(1, 1000)));
      t.exp = ref_model(t.op, t.a, t.b);
      t.lat = ref_lat(t.op, t.a, t.b);
      v.push_back(t);
    end
    run_vectors(v, "random");
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    int c1 = -1, c2 = -1;
    logic [31:0] r1 = '0, r2 = '0;
    bit drop = 0;
    exp_q.push_back('{3'd0, 32'd3, 32'd4, 32'd12, 33});
    exp_q.push_back('{3'd5, 32'd12, 32'd4, 32'd3, 33});
    @(negedge clk);
    mdu_op = 3'd0; operand1 = 32'd3; operand2 = 32'd4; start_valid = 1;
    @(posedge clk);
    // keep start_valid held with the next op while busy; it must wait for IDLE
    #1 mdu_op = 3'd5; operand1 = 32'd12; operand2 = 32'd4;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (result_valid) begin
        pulses++;
        if (pulses == 1) begin c1 = cyc; r1 = result; end
        if (pulses == 2) begin c2 = cyc; r2 = result; end
      end
      if (start_ready && pulses == 1 && start_valid) drop = 1;
      @(posedge clk);
      #1 if (drop) start_valid = 0;
    end
    start_valid = 0;
    begin
      vec_t e1, e2;
      e1 = exp_q.pop_front();
      e2 = exp_q.pop_front();
      checks++;
      if (pulses != 2) begin
        errors++;
        $display("FAIL b2b_pulses got=%0d exp=2", pulses);
      end
      checks++;
      if (r1 !== e1.exp) begin
        errors++;
        $display("FAIL b2b_first got=%h exp=%h", r1, e1.exp);
      end
      checks++;
      if (r2 !== e2.exp) begin
        errors++;
        $display("FAIL b2b_second got=%h exp=%h", r2, e2.exp);
      end
      checks++;
      if (c2 - c1 != 34) begin
        errors++;
        $display("FAIL b2b_spacing got=%0d exp=34", c2 - c1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_reset_mid();
    test_div();
    test_flush();
    test_special();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
